// File: rtl/axi_write_burst_gen.sv
// axi_write_burst_gen
//
// AXI4 write-channel engine for decompressed output. It accepts one job at a time
// (destination address plus byte length) and the 512-bit beat stream from the
// decompressor output FIFO. It produces AW/W/B traffic. Bursts are at most 64 beats
// and never cross a 4 KB boundary. job_done pulses once every write response of the
// job has returned.
//
// Optional feature (compile-time macro WR_PARTIAL_STRB_EN):
//   defined     : the final beat of a job whose length is not a multiple of 64 bytes
//                 carries wstrb = (1 << tail) - 1.
//   not defined : wstrb is always all ones, so the tail is written as a full beat.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   job_valid/job_ready         job handshake; job_des_addr (bits [5:0] ignored),
//                               job_length in bytes
//   s_data/s_valid/s_ready      beat stream from the output FIFO
//   awvalid/awready/awaddr/awlen  AXI write address channel
//   wdata/wstrb/wlast/wvalid/wready  AXI write data channel (wdata = s_data)
//   bvalid/bresp/bready         AXI write response channel
//   job_done                    one-cycle pulse when the job has fully completed
//   wr_error                    sticky: some bresp != 0 during the current job
//   idle                        high only while the AW FSM is idle
module axi_write_burst_gen #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
  parameter int unsigned MAX_OUTSTANDING    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            job_valid,
  output logic                            job_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   job_des_addr,
  input  logic [31:0]                     job_length,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic                            awvalid,
  input  logic                            awready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]                      awlen,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb,
  output logic                            wlast,
  output logic                            wvalid,
  input  logic                            wready,
  input  logic                            bvalid,
  input  logic [1:0]                      bresp,
  output logic                            bready,
  output logic                            job_done,
  output logic                            wr_error,
  output logic                            idle
);

  localparam int unsigned StrbW = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned PtrW  = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntW  = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StIssue, StDrain} state_e;

  state_e                          state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [26:0]                     beats_left_q, beats_left_d;
  logic [6:0]                      blen_q, blen_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [7:0]                      awlen_q, awlen_d;
  logic [CntW-1:0]                 outstanding_q, outstanding_d;
  logic                            wr_error_q, wr_error_d;
  logic                            job_done_q, job_done_d;

  // Burst-length FIFO: one entry per issued AW, popped on the matching wlast beat.
  logic [6:0]                      fifo_len_q [MAX_OUTSTANDING];
  logic [PtrW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]                 fifo_cnt_q, fifo_cnt_d;
  logic [6:0]                      beat_cnt_q, beat_cnt_d;

`ifdef WR_PARTIAL_STRB_EN
  logic [5:0]                      tail_q, tail_d;
  // Marks the entry holding the final burst of the job.
  logic                            fifo_last_q [MAX_OUTSTANDING];
`endif

  logic       job_accept;
  logic       aw_hs;
  logic       b_acc;
  logic       w_active;
  logic       w_hs;
  logic       w_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic       final_burst;
  logic [6:0] head_len;
  logic [6:0] to_bound;
  logic [6:0] blen_calc;

  // ---------------------------------------------------------------------------
  // Handshakes and channel outputs
  // ---------------------------------------------------------------------------
  assign fifo_full  = (fifo_cnt_q == CntW'(MAX_OUTSTANDING));
  assign fifo_empty = (fifo_cnt_q == '0);

  assign job_ready  = !rst && (state_q == StIdle);
  assign job_accept = job_valid && job_ready;
  assign idle       = (state_q == StIdle);

  // The FIFO full term never blocks legal traffic (FIFO occupancy cannot exceed
  // outstanding); it only protects the FIFO against B responses that arrive early.
  assign awvalid = !rst && (state_q == StIssue) &&
                   (outstanding_q < CntW'(MAX_OUTSTANDING)) && !fifo_full;
  assign aw_hs   = awvalid && awready;
  assign awaddr  = awaddr_q;
  assign awlen   = awlen_q;

  assign bready = !rst;
  // B with nothing outstanding is a protocol error and is dropped.
  assign b_acc  = bvalid && bready && (outstanding_q != '0);

  assign w_active = !rst && !fifo_empty;
  assign head_len = fifo_len_q[rd_ptr_q];
  assign wvalid   = s_valid && w_active;
  assign s_ready  = wready && w_active;
  assign wdata    = s_data;
  assign wlast    = w_active && (beat_cnt_q == head_len - 7'd1);
  assign w_hs     = wvalid && wready;
  assign w_pop    = w_hs && wlast;

`ifdef WR_PARTIAL_STRB_EN
  always_comb begin
    wstrb = '1;
    if (wlast && fifo_last_q[rd_ptr_q] && (tail_q != 6'd0)) begin
      wstrb = (StrbW'(1) << tail_q) - StrbW'(1);
    end
  end
`else
  assign wstrb = '1;
`endif

  assign job_done = job_done_q;
  assign wr_error = wr_error_q;

  // Beats remaining up to the next 4 KB boundary (1..64).
  assign to_bound  = 7'd64 - {1'b0, addr_q[11:6]};
  assign blen_calc = (beats_left_q < 27'(to_bound)) ? beats_left_q[6:0] : to_bound;

  assign final_burst = (beats_left_q == 27'(blen_q));

  // ---------------------------------------------------------------------------
  // AW FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beats_left_d = beats_left_q;
    blen_d       = blen_q;
    awaddr_d     = awaddr_q;
    awlen_d      = awlen_q;
    job_done_d   = 1'b0;
`ifdef WR_PARTIAL_STRB_EN
    tail_d       = tail_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (job_accept) begin
          addr_d       = {job_des_addr[C_M_AXI_ADDR_WIDTH-1:6], 6'b0};
          beats_left_d = {1'b0, job_length[31:6]} + 27'(|job_length[5:0]);
`ifdef WR_PARTIAL_STRB_EN
          tail_d       = job_length[5:0];
`endif
          state_d      = (job_length == 32'd0) ? StDrain : StCalc;
        end
      end
      StCalc: begin
        awaddr_d = addr_q;
        awlen_d  = {1'b0, blen_calc - 7'd1};
        blen_d   = blen_calc;
        state_d  = StIssue;
      end
      StIssue: begin
        if (aw_hs) begin
          addr_d       = addr_q + C_M_AXI_ADDR_WIDTH'({blen_q, 6'b0});
          beats_left_d = beats_left_q - 27'(blen_q);
          state_d      = final_burst ? StDrain : StCalc;
        end
      end
      StDrain: begin
        // Look at next-state counters so done lands the cycle after the last B.
        if ((outstanding_d == '0) && (fifo_cnt_d == '0)) begin
          job_done_d = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outstanding counter, error flag, FIFO pointers, beat counter
  // ---------------------------------------------------------------------------
  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({aw_hs, b_acc})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    wr_error_d = wr_error_q;
    if (job_accept) begin
      wr_error_d = 1'b0;
    end else if (b_acc && (bresp != 2'b00)) begin
      wr_error_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PtrW'(aw_hs);
    rd_ptr_d   = rd_ptr_q + PtrW'(w_pop);
    fifo_cnt_d = fifo_cnt_q;
    unique case ({aw_hs, w_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    beat_cnt_d = beat_cnt_q;
    if (w_hs) begin
      beat_cnt_d = wlast ? 7'd0 : beat_cnt_q + 7'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      beats_left_q  <= '0;
      blen_q        <= '0;
      awaddr_q      <= '0;
      awlen_q       <= '0;
      outstanding_q <= '0;
      wr_error_q    <= 1'b0;
      job_done_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      beat_cnt_q    <= '0;
`ifdef WR_PARTIAL_STRB_EN
      tail_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      beats_left_q  <= beats_left_d;
      blen_q        <= blen_d;
      awaddr_q      <= awaddr_d;
      awlen_q       <= awlen_d;
      outstanding_q <= outstanding_d;
      wr_error_q    <= wr_error_d;
      job_done_q    <= job_done_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
`ifdef WR_PARTIAL_STRB_EN
      tail_q        <= tail_d;
`endif
    end
  end

  // FIFO storage needs no reset: entries are only read while the count is non-zero.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      fifo_len_q[wr_ptr_q] <= blen_q;
`ifdef WR_PARTIAL_STRB_EN
      fifo_last_q[wr_ptr_q] <= final_burst;
`endif
    end
  end

endmodule

// File: tb/tb_axi_write_burst_gen.sv
module tb_axi_write_burst_gen;

  localparam logic [63:0] ALL1 = {64{1'b1}};

  logic         clk = 1'b0;
  logic         rst;
  logic         job_valid;
  logic         job_ready;
  logic [63:0]  job_des_addr;
  logic [31:0]  job_length;
  logic [511:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic         awvalid;
  logic         awready;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic         bvalid;
  logic [1:0]   bresp;
  logic         bready;
  logic         job_done;
  logic         wr_error;
  logic         idle;

  axi_write_burst_gen #(
    .C_M_AXI_ADDR_WIDTH(64),
    .C_M_AXI_DATA_WIDTH(512),
    .MAX_OUTSTANDING   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_des_addr(job_des_addr),
    .job_length  (job_length),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .awvalid     (awvalid),
    .awready     (awready),
    .awaddr      (awaddr),
    .awlen       (awlen),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wlast       (wlast),
    .wvalid      (wvalid),
    .wready      (wready),
    .bvalid      (bvalid),
    .bresp       (bresp),
    .bready      (bready),
    .job_done    (job_done),
    .wr_error    (wr_error),
    .idle        (idle)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
  } aw_exp_t;

  typedef struct packed {
    logic [31:0] idx;
    logic        last;
    logic [63:0] strb;
  } w_exp_t;

  aw_exp_t aw_q[$];
  w_exp_t  w_q[$];
  logic    done_q[$];

  int chk_cnt = 0;
  int err_cnt = 0;
  int aw_cnt  = 0;
  int w_cnt   = 0;
  int b_cnt   = 0;
  int err_at  = -1;
  int w_push_idx = 0;
  bit b_en = 1'b1;

  function automatic logic [511:0] pat(input int unsigned i);
    return {16{i}};
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string detail);
    chk_cnt++;
    err_cnt++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // Expected AW plus its W beats, hand-computed by the caller.
  task automatic push_burst(input logic [63:0] a, input int beats, input logic [63:0] last_strb);
    aw_q.push_back('{addr: a, len: 8'(beats - 1)});
    for (int i = 0; i < beats; i++) begin
      w_q.push_back('{idx: w_push_idx, last: (i == beats - 1),
                      strb: (i == beats - 1) ? last_strb : ALL1});
      w_push_idx++;
    end
  endtask

  // Monitor: samples at negedge; a handshake seen here completes at the next posedge.
  initial begin
    aw_exp_t ea;
    w_exp_t  ew;
    logic    ed;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (awvalid && awready) begin
          aw_cnt++;
          if (aw_q.size() == 0) begin
            fail("aw_unexpected", $sformatf("got awaddr %0h, expected no AW", awaddr));
          end else begin
            ea = aw_q.pop_front();
            check("awaddr", awaddr, ea.addr);
            check("awlen", awlen, ea.len);
          end
        end
        if (wvalid && wready) begin
          w_cnt++;
          if (w_q.size() == 0) begin
            fail("w_unexpected", "got W beat, expected no W");
          end else begin
            ew = w_q.pop_front();
            check("wdata", wdata, pat(ew.idx));
            check("wlast", wlast, ew.last);
            check("wstrb", wstrb, ew.strb);
          end
        end
        if (bvalid && bready) b_cnt++;
        if (job_done) begin
          if (done_q.size() == 0) begin
            fail("done_unexpected", "got job_done, expected none");
          end else begin
            ed = done_q.pop_front();
            check("wr_error_at_done", wr_error, ed);
          end
        end
      end
    end
  end

  // Source FIFO and B responder.
  initial begin
    int          pend;
    int unsigned src;
    logic        s_hs, wl_hs, b_hs;
    pend   = 0;
    src    = 0;
    s_data = pat(0);
    bvalid = 1'b0;
    bresp  = 2'b00;
    forever begin
      @(negedge clk);
      s_hs  = s_valid && s_ready;
      wl_hs = wvalid && wready && wlast;
      b_hs  = bvalid && bready;
      @(posedge clk);
      #2;
      if (rst) begin
        pend = 0;
        src  = 0;
      end else begin
        if (s_hs)  src++;
        if (wl_hs) pend++;
        if (b_hs)  pend--;
      end
      s_data = pat(src);
      bvalid = b_en && (pend > 0);
      bresp  = (b_cnt == err_at) ? 2'b10 : 2'b00;
    end
  end

  task automatic accept(input logic [63:0] a, input logic [31:0] l);
    int n = 0;
    @(posedge clk);
    #1;
    job_valid    = 1'b1;
    job_des_addr = a;
    job_length   = l;
    while (!job_ready && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!job_ready) fail("job_accept", "got job_ready low for 1000 cycles, expected accept");
    @(posedge clk);
    #1;
    job_valid = 1'b0;
  endtask

  // Called one cycle after accept; returns how many cycles after accept job_done rose.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!job_done && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!job_done) fail("job_done_timeout", "got no job_done in 3000 cycles, expected pulse");
  endtask

  initial begin
    int            cyc;
    int            base_aw, base_w, base_b;
    logic [63:0]   strb100;
    rst          = 1'b1;
    job_valid    = 1'b0;
    job_des_addr = '0;
    job_length   = '0;
    s_valid      = 1'b1;
    awready      = 1'b1;
    wready       = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_bready", bready, 1'b0);
    check("rst_job_ready", job_ready, 1'b0);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_wlast", wlast, 1'b0);
    check("rst_job_done", job_done, 1'b0);
    check("rst_wr_error", wr_error, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_bready", bready, 1'b1);
    check("post_rst_idle", idle, 1'b1);
    check("post_rst_job_ready", job_ready, 1'b1);
    check("post_rst_awaddr", awaddr, 64'h0);
    check("post_rst_awlen", awlen, 8'h0);

    // 0x1000, 8 KB: two full bursts.
    push_burst(64'h1000, 64, ALL1);
    push_burst(64'h2000, 64, ALL1);
    done_q.push_back(1'b0);
    accept(64'h1000, 32'd8192);
    check("calc_idle", idle, 1'b0);
    cyc = 1;
    while (!awvalid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("first_aw_latency", cyc, 2);
    wait_done(cyc);

    // 0x1FC0, 256 B: boundary split 1 + 3 beats; AW held under awready low.
    push_burst(64'h1FC0, 1, ALL1);
    push_burst(64'h2000, 3, ALL1);
    done_q.push_back(1'b0);
    awready = 1'b0;
    accept(64'h1FC0, 32'd256);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("aw_hold_valid", awvalid, 1'b1);
      check("aw_hold_addr", awaddr, 64'h1FC0);
      check("aw_hold_len", awlen, 8'd0);
      @(posedge clk);
      #1;
    end
    awready = 1'b1;
    wait_done(cyc);

    // 100 B: two beats, partial strobe on the tail when enabled.
`ifdef WR_PARTIAL_STRB_EN
    strb100 = 64'h0000_000F_FFFF_FFFF;
`else
    strb100 = ALL1;
`endif
    push_burst(64'h3000, 2, strb100);
    done_q.push_back(1'b0);
    accept(64'h3000, 32'd100);
    wait_done(cyc);

    // 16 KB with B withheld: only MAX_OUTSTANDING=2 AWs go out.
    push_burst(64'h40000, 64, ALL1);
    push_burst(64'h41000, 64, ALL1);
    push_burst(64'h42000, 64, ALL1);
    push_burst(64'h43000, 64, ALL1);
    done_q.push_back(1'b0);
    @(posedge clk);
    #1;
    b_en    = 1'b0;
    base_aw = aw_cnt;
    base_b  = b_cnt;
    accept(64'h40000, 32'd16384);
    repeat (200) @(posedge clk);
    #1;
    check("blocked_aw_count", aw_cnt - base_aw, 2);
    check("blocked_awvalid", awvalid, 1'b0);
    b_en = 1'b1;
    wait_done(cyc);
    check("b_count_at_done", b_cnt - base_b, 4);
    check("aw_count_16k", aw_cnt - base_aw, 4);

    // Zero length: no AW/W, done 2 cycles after accept.
    base_aw = aw_cnt;
    base_w  = w_cnt;
    done_q.push_back(1'b0);
    accept(64'h5000, 32'd0);
    check("len0_idle", idle, 1'b0);
    wait_done(cyc);
    check("len0_done_latency", cyc, 2);
    check("len0_no_aw", aw_cnt - base_aw, 0);
    check("len0_no_w", w_cnt - base_w, 0);

    // Error on the second B of a 3-burst job; sticky until next accept.
    push_burst(64'h10000, 64, ALL1);
    push_burst(64'h11000, 64, ALL1);
    push_burst(64'h12000, 1, ALL1);
    done_q.push_back(1'b1);
    err_at = b_cnt + 1;
    accept(64'h10000, 32'd8256);
    wait_done(cyc);
    @(posedge clk);
    #1;
    check("wr_error_sticky", wr_error, 1'b1);
    err_at = -1;
    done_q.push_back(1'b0);
    accept(64'h6000, 32'd0);
    check("wr_error_cleared", wr_error, 1'b0);
    wait_done(cyc);

    repeat (5) @(posedge clk);
    #1;
    check("aw_queue_drained", aw_q.size(), 0);
    check("w_queue_drained", w_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    fail("watchdog", "got no end of test by 2 ms, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/axi_write_burst_gen.md
# axi_write_burst_gen

AXI4 write-channel engine for decompressed output. It sits directly downstream of the decompressor output FIFO. It takes one job at a time (destination address plus byte length) and the 512-bit beat stream from that FIFO, and produces AW/W/B traffic. Bursts are at most 64 beats (4 KB) and never cross a 4 KB boundary. When every write response of the job has returned, it pulses `job_done`.

## Interface
Parameters:
- `C_M_AXI_ADDR_WIDTH`, 64, AW address width.
- `C_M_AXI_DATA_WIDTH`, 512, W data width (fixed 64 B per beat).
- `MAX_OUTSTANDING`, 8, maximum issued bursts awaiting B; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `job_valid`  in  1  new job offered.
- `job_ready`  out  1  job accepted when `job_valid & job_ready`.
- `job_des_addr`  in  64  destination byte address; bits [5:0] forced to 0.
- `job_length`  in  32  byte count.
- `s_data`  in  512  beat from output FIFO.
- `s_valid`  in  1  beat valid.
- `s_ready`  out  1  beat consumed when `s_valid & s_ready`.
- `awvalid`  out  1  AW request.
- `awready`  in  1  AW accept.
- `awaddr`  out  64  burst start address.
- `awlen`  out  8  beats minus one.
- `wdata`  out  512  equals `s_data`.
- `wstrb`  out  64  byte enables.
- `wlast`  out  1  final beat of the burst.
- `wvalid`  out  1  W valid.
- `wready`  in  1  W accept.
- `bvalid`  in  1  response valid.
- `bresp`  in  2  response code.
- `bready`  out  1  always 1 outside reset.
- `job_done`  out  1  one-cycle pulse at job completion.
- `wr_error`  out  1  sticky: some `bresp != 0` in the current job.
- `idle`  out  1  no job in flight.

## Operation
- The AW FSM has four states: IDLE, CALC, ISSUE, DRAIN.

IDLE:
- `job_ready = 1`.
- On accept, latch the address and set `beats_left = ceil(job_length/64)` (27-bit).
- Latch `tail = job_length[5:0]`.
- Clear `wr_error`.
- Go to CALC.
- If `job_length == 0`: go straight to DRAIN; no AW/W is issued.

CALC:
- `to_bound = 64 - addr[11:6]`.
- `blen = min(beats_left, to_bound)`.
- `awaddr` gets the current address; `awlen = blen - 1`.
- Go to ISSUE.

ISSUE:
- Hold `awvalid = 1` while outstanding < `MAX_OUTSTANDING`; otherwise hold `awvalid = 0` and wait.
- On AW handshake:
  - push `blen` into the burst-length FIFO (depth `MAX_OUTSTANDING`);
  - increment `outstanding`;
  - `addr += blen*64`; `beats_left -= blen`.
- Then go to CALC if `beats_left != 0`, else DRAIN.

DRAIN:
- Wait until `outstanding == 0` and the burst-length FIFO is empty.
- Then pulse `job_done` and return to IDLE.

W path:
- Active when the burst-length FIFO is non-empty.
- `wvalid = s_valid & active`; `s_ready = wready & active` (combinational pass-through).
- A beat counter compares against the FIFO head; `wlast` is asserted on beat `head-1`, and the FIFO pops on the `wlast` handshake.

B path:
- Each `bvalid` decrements `outstanding`.
- Non-zero `bresp` sets `wr_error`.
- AW handshake and B in the same cycle leave `outstanding` unchanged.

Other rules:
- Bursts arriving with `outstanding == 0` are ignored as protocol errors; no underflow.
- `idle = 1` in IDLE only.

## Timing
- Reset values:
  - `job_ready`, `awvalid`, `wvalid`, `s_ready`, `wlast`, `job_done`, `wr_error`, `bready`: 0 during reset.
  - `bready`: 1 from the first cycle after reset.
  - `idle`, `job_ready`: 1 from the first cycle after reset.
  - `awaddr`, `awlen`: 0.
- Latency and throughput:
  - First `awvalid` is asserted 2 cycles after job accept (accept → CALC → ISSUE).
  - Consecutive AW requests are at least 2 cycles apart.
  - The W channel sustains 1 beat/cycle once its burst is queued.
  - W never precedes its own AW handshake.
- `job_done` is asserted the cycle after the last B with the FIFO empty.
- AXI stability: `awvalid` and `awaddr`/`awlen` are held stable until `awready`.
- Reset mid-job: all counters, FIFOs and FSMs return to reset state; the in-flight AXI transaction is abandoned.

## Configuration
- `WR_PARTIAL_STRB_EN` defined: `wstrb` is all ones except the last beat of a job with `tail != 0`. That beat gets `wstrb = (64'h1 << tail) - 1`.
- Not defined: `wstrb` is always `64'hFFFF_FFFF_FFFF_FFFF`, and the tail is written as a full beat.

## Test plan
- Address 0x1000, length 8192, all ready high → two AW (0x1000 and 0x2000, awlen 63) and 128 W beats. `wlast` lands on beats 64 and 128; one `job_done`.
- Address 0x1FC0, length 256 → AW 0x1FC0 with awlen 0, then AW 0x2000 with awlen 2. `wlast` after beats 1 and 4.
- Length 100 with `WR_PARTIAL_STRB_EN` → 2 beats, last `wstrb = 64'h0000_000F_FFFF_FFFF`. Without the macro, the last beat is all ones.
- `MAX_OUTSTANDING = 2`, `bvalid` withheld, length 16384 → exactly 2 AW accepted and `awvalid` drops. Releasing B resumes issue; `job_done` follows the 4th B.
- Length 0 → no AW or W activity, and `job_done` asserts 2 cycles after accept.
- Second B returns `bresp = 2'b10` → `wr_error = 1` through `job_done`; it clears on the next accept.
